// File: rtl/sdram_arb_pkg.sv
// Shared width defaults, FSM state encoding and tag record for the SDRAM read arbiter.
package sdram_arb_pkg;
  localparam int ADDR_W_DEF    = 29;
  localparam int DATA_W_DEF    = 64;
  localparam int BURST_W_DEF   = 8;
  localparam int MAX_OUTST_DEF = 4;
  // Tag burstcount field is sized for the widest burstcount the arbiter accepts.
  localparam int TAG_BC_W      = 16;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  typedef struct packed {
    logic                id;
    logic [TAG_BC_W-1:0] burstcount;
  } tag_t;
endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Synchronous first-word-fall-through FIFO holding {id, burstcount} of issued read bursts.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DEF,
  parameter int WIDTH = $bits(tag_t)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/sdram_rd_arbiter.sv
// Two-requester round-robin Avalon-MM read arbiter in front of an HPS f2h_sdram port.
// Optional SDRAM_RD_ARB_ERR_EN: flags beats that arrive with no outstanding tag on err.
module sdram_rd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_W   = BURST_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               rq0_read,
  input  logic [ADDR_W-1:0]  rq0_address,
  input  logic [BURST_W-1:0] rq0_burstcount,
  output logic               rq0_waitrequest,
  output logic [DATA_W-1:0]  rq0_readdata,
  output logic               rq0_readdatavalid,
  input  logic               rq1_read,
  input  logic [ADDR_W-1:0]  rq1_address,
  input  logic [BURST_W-1:0] rq1_burstcount,
  output logic               rq1_waitrequest,
  output logic [DATA_W-1:0]  rq1_readdata,
  output logic               rq1_readdatavalid,
  output logic               avm_read,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [BURST_W-1:0] avm_burstcount,
  input  logic               avm_waitrequest,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  output logic               err
);
  localparam int TAG_W = $bits(tag_t);

  state_t              state;
  state_t              state_nxt;
  logic                rr_ptr;
  logic                grant_id;
  logic                grant_req;
  logic                grant_sel;
  logic                accept;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  bc_q;
  tag_t                tag_in;
  tag_t                tag_head;
  logic [TAG_W-1:0]    head_bits;
  logic                fifo_full;
  logic                fifo_empty;
  logic                beat_ok;
  logic                last_beat;
  logic [TAG_BC_W-1:0] beat_cnt;
  logic                rq0_vld_p0;
  logic                rq1_vld_p0;
  logic [DATA_W-1:0]   rq0_data_p0;
  logic [DATA_W-1:0]   rq1_data_p0;

  // A zero burstcount is treated as a single-beat burst both on the bus and in the tag.
  function automatic logic [BURST_W-1:0] norm_burst(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

  always_comb begin
    state_nxt = state;
    grant_req = 1'b0;
    grant_sel = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if ((rq0_read || rq1_read) && !fifo_full) begin
          grant_req = 1'b1;
          grant_sel = (rq0_read && rq1_read) ? rr_ptr : rq1_read;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  // rr_ptr names the requester that wins the next tie.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rr_ptr   <= 1'b0;
      grant_id <= 1'b0;
      addr_q   <= '0;
      bc_q     <= '0;
    end else if (grant_req) begin
      rr_ptr   <= ~grant_sel;
      grant_id <= grant_sel;
      addr_q   <= grant_sel ? rq1_address : rq0_address;
      bc_q     <= norm_burst(grant_sel ? rq1_burstcount : rq0_burstcount);
    end
  end

  assign avm_read        = (state == ISSUE);
  assign avm_address     = addr_q;
  assign avm_burstcount  = bc_q;
  assign rq0_waitrequest = !(accept && !grant_id);
  assign rq1_waitrequest = !(accept && grant_id);

  always_comb begin
    tag_in.id         = grant_id;
    tag_in.burstcount = TAG_BC_W'(bc_q);
  end

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (accept),
    .din   (tag_in),
    .pop   (last_beat),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tag_head  = tag_t'(head_bits);
  assign beat_ok   = avm_readdatavalid && !fifo_empty;
  assign last_beat = beat_ok && ((beat_cnt + 1'b1) == tag_head.burstcount);

  // ---- p0: response beat registered toward the owning requester
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      beat_cnt   <= '0;
      rq0_vld_p0 <= 1'b0;
      rq1_vld_p0 <= 1'b0;
    end else begin
      rq0_vld_p0 <= beat_ok && !tag_head.id;
      rq1_vld_p0 <= beat_ok && tag_head.id;
      if (last_beat)    beat_cnt <= '0;
      else if (beat_ok) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (beat_ok && !tag_head.id) rq0_data_p0 <= avm_readdata;
    if (beat_ok && tag_head.id)  rq1_data_p0 <= avm_readdata;
  end

  assign rq0_readdata      = rq0_data_p0;
  assign rq1_readdata      = rq1_data_p0;
  assign rq0_readdatavalid = rq0_vld_p0;
  assign rq1_readdatavalid = rq1_vld_p0;

`ifdef SDRAM_RD_ARB_ERR_EN
  logic err_q;
  always_ff @(posedge clk_clk) begin
    if (reset_reset)                          err_q <= 1'b0;
    else if (avm_readdatavalid && fifo_empty) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed self-checking bench for sdram_rd_arbiter: vector table plus multi-cycle sequences.
module tb_sdram_rd_arbiter;
  localparam int ADDR_W    = 29;
  localparam int DATA_W    = 64;
  localparam int BURST_W   = 8;
  localparam int MAX_OUTST = 4;
`ifdef SDRAM_RD_ARB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] ADDR0 = 29'h100;
  localparam logic [ADDR_W-1:0] ADDR1 = 29'h200;
  localparam logic [ADDR_W-1:0] ADDR2 = 29'h300;

  logic               clk_clk = 1'b0;
  logic               reset_reset;
  logic               rq0_read, rq1_read;
  logic [ADDR_W-1:0]  rq0_address, rq1_address;
  logic [BURST_W-1:0] rq0_burstcount, rq1_burstcount;
  logic               rq0_waitrequest, rq1_waitrequest;
  logic [DATA_W-1:0]  rq0_readdata, rq1_readdata;
  logic               rq0_readdatavalid, rq1_readdatavalid;
  logic               avm_read;
  logic [ADDR_W-1:0]  avm_address;
  logic [BURST_W-1:0] avm_burstcount;
  logic               avm_waitrequest;
  logic [DATA_W-1:0]  avm_readdata;
  logic               avm_readdatavalid;
  logic               err;

  always #5 clk_clk = ~clk_clk;

  sdram_rd_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .BURST_W (BURST_W), .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk_clk (clk_clk), .reset_reset (reset_reset),
    .rq0_read (rq0_read), .rq0_address (rq0_address), .rq0_burstcount (rq0_burstcount),
    .rq0_waitrequest (rq0_waitrequest), .rq0_readdata (rq0_readdata),
    .rq0_readdatavalid (rq0_readdatavalid),
    .rq1_read (rq1_read), .rq1_address (rq1_address), .rq1_burstcount (rq1_burstcount),
    .rq1_waitrequest (rq1_waitrequest), .rq1_readdata (rq1_readdata),
    .rq1_readdatavalid (rq1_readdatavalid),
    .avm_read (avm_read), .avm_address (avm_address), .avm_burstcount (avm_burstcount),
    .avm_waitrequest (avm_waitrequest), .avm_readdata (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid), .err (err)
  );

  typedef struct {
    logic         r0;
    logic         r1;
    logic [7:0]   bc0;
    logic [7:0]   bc1;
    logic         exp_req;
    logic         exp_id;
    logic [7:0]   exp_bc;
  } vec_t;

  vec_t        vecs[9];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ngrant;
  logic        order[4];
  logic        seen_read;
  logic        owners[5];
  logic [63:0] d;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input int r, input int b);
    return 64'hA5A5_0000_0000_0000 + 64'(r) * 64'h1_0000 + 64'(b);
  endfunction

  task automatic do_reset();
    rq0_read = 1'b0; rq1_read = 1'b0;
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    reset_reset = 1'b1;
    tick();
    tick();
    reset_reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check1({tag, " avm_read"}, avm_read, 1'b0);
    check64({tag, " avm_address"}, 64'(avm_address), 64'd0);
    check64({tag, " avm_burstcount"}, 64'(avm_burstcount), 64'd0);
    check1({tag, " rq0_waitrequest"}, rq0_waitrequest, 1'b1);
    check1({tag, " rq1_waitrequest"}, rq1_waitrequest, 1'b1);
    check1({tag, " rq0_readdatavalid"}, rq0_readdatavalid, 1'b0);
    check1({tag, " rq1_readdatavalid"}, rq1_readdatavalid, 1'b0);
    check1({tag, " err"}, err, 1'b0);
  endtask

  // Drive one beat and check it lands on the expected requester one cycle later.
  task automatic beat_expect(input string tag, input logic owner, input logic [63:0] data);
    avm_readdatavalid = 1'b1;
    avm_readdata      = data;
    tick();
    check1({tag, " own vld"}, owner ? rq1_readdatavalid : rq0_readdatavalid, 1'b1);
    check1({tag, " other vld"}, owner ? rq0_readdatavalid : rq1_readdatavalid, 1'b0);
    check64({tag, " data"}, owner ? rq1_readdata : rq0_readdata, data);
    avm_readdatavalid = 1'b0;
  endtask

  initial begin
    rq0_address = ADDR0; rq1_address = ADDR1;
    rq0_burstcount = '0; rq1_burstcount = '0;
    avm_readdata = '0;
    //            r0    r1    bc0   bc1   req   id    exp_bc
    vecs[0] = '{1'b1, 1'b0, 8'd4, 8'd0, 1'b1, 1'b0, 8'd4};
    vecs[1] = '{1'b1, 1'b1, 8'd2, 8'd3, 1'b1, 1'b1, 8'd3};
    vecs[2] = '{1'b1, 1'b1, 8'd2, 8'd3, 1'b1, 1'b0, 8'd2};
    vecs[3] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 8'd1};
    vecs[4] = '{1'b0, 1'b0, 8'd3, 8'd3, 1'b0, 1'b0, 8'd0};
    vecs[5] = '{1'b0, 1'b1, 8'd0, 8'd1, 1'b1, 1'b1, 8'd1};
    vecs[6] = '{1'b1, 1'b1, 8'd1, 8'd2, 1'b1, 1'b0, 8'd1};
    vecs[7] = '{1'b1, 1'b0, 8'd0, 8'd6, 1'b1, 1'b0, 8'd1};
    vecs[8] = '{1'b1, 1'b1, 8'd5, 8'd2, 1'b1, 1'b1, 8'd2};

    do_reset();
    check_reset_state("reset");

    for (int i = 0; i < 9; i++) begin
      rq0_read = vecs[i].r0; rq1_read = vecs[i].r1;
      rq0_burstcount = vecs[i].bc0; rq1_burstcount = vecs[i].bc1;
      tick();
      check1($sformatf("v%0d avm_read", i), avm_read, vecs[i].exp_req);
      if (vecs[i].exp_req) begin
        check64($sformatf("v%0d avm_address", i), 64'(avm_address),
                64'(vecs[i].exp_id ? ADDR1 : ADDR0));
        check64($sformatf("v%0d avm_burstcount", i), 64'(avm_burstcount), 64'(vecs[i].exp_bc));
        check1($sformatf("v%0d own waitrequest", i),
               vecs[i].exp_id ? rq1_waitrequest : rq0_waitrequest, 1'b0);
        check1($sformatf("v%0d other waitrequest", i),
               vecs[i].exp_id ? rq0_waitrequest : rq1_waitrequest, 1'b1);
      end
      rq0_read = 1'b0; rq1_read = 1'b0;
      if (vecs[i].exp_req) begin
        tick();
        for (int b = 0; b < int'(vecs[i].exp_bc); b++)
          beat_expect($sformatf("v%0d beat%0d", i, b), vecs[i].exp_id, beat_data(i, b));
      end
      tick();
      check1($sformatf("v%0d idle vld0", i), rq0_readdatavalid, 1'b0);
      check1($sformatf("v%0d idle vld1", i), rq1_readdatavalid, 1'b0);
    end
    check1("table err", err, 1'b0);

    // Continuous requests from both: alternate grants, then the outstanding limit.
    do_reset();
    rq0_address = ADDR0; rq1_address = ADDR1;
    rq0_burstcount = 8'd1; rq1_burstcount = 8'd1;
    rq0_read = 1'b1; rq1_read = 1'b1;
    ngrant = 0;
    for (int c = 0; c < 20 && ngrant < 4; c++) begin
      tick();
      if (!rq0_waitrequest || !rq1_waitrequest) begin
        order[ngrant] = !rq1_waitrequest;
        ngrant++;
        if (ngrant == 4) begin
          rq0_read = 1'b0; rq1_read = 1'b0;
        end
      end
    end
    check64("rr grant count", 64'(ngrant), 64'd4);
    for (int k = 0; k < 4; k++)
      check1($sformatf("rr grant%0d", k), order[k], k[0]);
    tick();
    rq0_read = 1'b1; rq0_address = ADDR2; rq0_burstcount = 8'd2;
    seen_read = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen_read = seen_read | avm_read;
    end
    check1("full no 5th read", seen_read, 1'b0);
    beat_expect("full pop beat", 1'b0, beat_data(20, 0));
    check1("full read at pop", avm_read, 1'b0);
    tick();
    check1("resume avm_read", avm_read, 1'b1);
    check64("resume address", 64'(avm_address), 64'(ADDR2));
    check64("resume burstcount", 64'(avm_burstcount), 64'd2);
    check1("resume accept", rq0_waitrequest, 1'b0);
    rq0_read = 1'b0;
    tick();
    owners = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++)
      beat_expect($sformatf("order beat%0d", k), owners[k], beat_data(21, k));

    // Slave stall: command held stable for 5 cycles, accepted on the 6th.
    do_reset();
    avm_waitrequest = 1'b1;
    rq1_read = 1'b1; rq1_address = 29'h2AB; rq1_burstcount = 8'd7;
    tick();
    rq1_address = 29'h1555;
    rq1_burstcount = 8'd9;
    for (int c = 1; c <= 5; c++) begin
      check1($sformatf("stall%0d avm_read", c), avm_read, 1'b1);
      check64($sformatf("stall%0d address", c), 64'(avm_address), 64'h2AB);
      check64($sformatf("stall%0d burstcount", c), 64'(avm_burstcount), 64'd7);
      check1($sformatf("stall%0d rq1_waitrequest", c), rq1_waitrequest, 1'b1);
      check1($sformatf("stall%0d rq0_waitrequest", c), rq0_waitrequest, 1'b1);
      tick();
    end
    avm_waitrequest = 1'b0;
    #1;
    check1("stall6 avm_read", avm_read, 1'b1);
    check1("stall6 rq1 accept", rq1_waitrequest, 1'b0);
    check1("stall6 rq0 waitrequest", rq0_waitrequest, 1'b1);
    tick();
    rq1_read = 1'b0;
    check1("stall done avm_read", avm_read, 1'b0);

    // Orphan beats: with no tags, and after a reset in the middle of a burst.
    do_reset();
    avm_readdatavalid = 1'b1; avm_readdata = 64'hDEAD;
    tick();
    avm_readdatavalid = 1'b0;
    check1("orphan vld0", rq0_readdatavalid, 1'b0);
    check1("orphan vld1", rq1_readdatavalid, 1'b0);
    check1("orphan err", err, ERR_EXP);
    rq0_read = 1'b1; rq0_address = ADDR0; rq0_burstcount = 8'd4;
    tick();
    rq0_read = 1'b0;
    tick();
    beat_expect("mid beat0", 1'b0, beat_data(30, 0));
    beat_expect("mid beat1", 1'b0, beat_data(30, 1));
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    check_reset_state("mid reset");
    for (int b = 2; b < 4; b++) begin
      avm_readdatavalid = 1'b1; avm_readdata = beat_data(30, b);
      tick();
      check1($sformatf("post-reset beat%0d vld0", b), rq0_readdatavalid, 1'b0);
      check1($sformatf("post-reset beat%0d vld1", b), rq1_readdatavalid, 1'b0);
    end
    avm_readdatavalid = 1'b0;
    check1("post-reset err", err, ERR_EXP);
    rq1_read = 1'b1; rq1_address = ADDR1; rq1_burstcount = 8'd1;
    tick();
    check1("post-reset avm_read", avm_read, 1'b1);
    rq1_read = 1'b0;
    tick();
    d = beat_data(31, 0);
    beat_expect("post-reset fresh beat", 1'b1, d);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
